// File: rtl/sprite_attr_bank.sv
// sprite_attr_bank
//   Double-buffered sprite attribute table. The CPU writes sprite words into a
//   shadow bank over an Avalon-MM slave. On a falling vsync edge the whole
//   shadow bank is copied into the active bank in one cycle, but only when a
//   commit is pending or auto-commit is on. This keeps the renderer from ever
//   seeing a half-updated frame.
// Ports
//   clk_clk, reset_reset_n     clock and synchronous active-low reset
//   avs_address/write/writedata/read/readdata
//                              Avalon-MM slave. Read data is registered (1-cycle latency).
//   vga_vs_n                   VGA vsync, active low, already in the clk_clk domain
//   irq                        level interrupt: irq flag & IRQ_EN
//   spr_en/x/y/flags           active-bank outputs; sprite i occupies slice i of each bus
// Register map
//   0..NUM_SPRITES-1  sprite word {en[31], flags, y, x}; reads return shadow
//   NUM_SPRITES       CTRL:   b0 PEND (write-1-set), b1 AUTO, b2 IRQ_EN, b3 IRQ_CLR (write-1, reads 0)
//   NUM_SPRITES+1     STATUS: [15:0] commit count, [16] irq flag (read-only)
module sprite_attr_bank #(
  parameter int NUM_SPRITES = 16,
  parameter int COORD_W     = 10,
  parameter int FLAG_W      = 4,
  parameter int ADDR_W      = 5
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [ADDR_W-1:0]              avs_address,
  input  logic                           avs_write,
  input  logic [31:0]                    avs_writedata,
  input  logic                           avs_read,
  output logic [31:0]                    avs_readdata,
  input  logic                           vga_vs_n,
  output logic                           irq,
  output logic [NUM_SPRITES-1:0]         spr_en,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  output logic [NUM_SPRITES*FLAG_W-1:0]  spr_flags
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_SPRITES);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_SPRITES + 1);

  logic [NUM_SPRITES-1:0]              r_sh_en, r_act_en;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] r_sh_x, r_sh_y, r_act_x, r_act_y;
  logic [NUM_SPRITES-1:0][FLAG_W-1:0]  r_sh_f, r_act_f;

  logic        r_pend, r_auto, r_irq_en, r_irq_flag, r_vs_d;
  logic [15:0] r_cnt;

  logic        w_vs_fall, w_commit, w_wr_ctrl;
  logic [31:0] w_rd;

  // The history register resets low, so a vsync that is already low when
  // reset is released cannot count as a falling edge.
  assign w_vs_fall = r_vs_d & ~vga_vs_n;
  // Uses PEND/AUTO as they were before this cycle. A CTRL write in the same
  // cycle only affects the next frame.
  assign w_commit  = w_vs_fall & (r_pend | r_auto);
  assign w_wr_ctrl = avs_write & (avs_address == A_CTRL);

  // Per-sprite shadow/active pair. The active bank samples the shadow value
  // from before any write in the same cycle, so that write waits for the
  // next commit.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic w_wr;
    assign w_wr = avs_write & (avs_address == ADDR_W'(i));
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        r_sh_en[i]  <= 1'b0;
        r_sh_x[i]   <= '0;
        r_sh_y[i]   <= '0;
        r_sh_f[i]   <= '0;
        r_act_en[i] <= 1'b0;
        r_act_x[i]  <= '0;
        r_act_y[i]  <= '0;
        r_act_f[i]  <= '0;
      end else begin
        if (w_commit) begin
          r_act_en[i] <= r_sh_en[i];
          r_act_x[i]  <= r_sh_x[i];
          r_act_y[i]  <= r_sh_y[i];
          r_act_f[i]  <= r_sh_f[i];
        end
        if (w_wr) begin
          r_sh_en[i] <= avs_writedata[31];
          r_sh_x[i]  <= avs_writedata[COORD_W-1:0];
          r_sh_y[i]  <= avs_writedata[2*COORD_W-1:COORD_W];
          r_sh_f[i]  <= avs_writedata[2*COORD_W+FLAG_W-1:2*COORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_vs_d     <= 1'b0;
      r_pend     <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_flag <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_vs_d <= vga_vs_n;
      // The commit clears the PEND it consumed. A same-cycle write of 1
      // re-arms PEND for the next frame.
      if (w_wr_ctrl && avs_writedata[0]) r_pend <= 1'b1;
      else if (w_commit)                 r_pend <= 1'b0;
      if (w_wr_ctrl) begin
        r_auto   <= avs_writedata[1];
        r_irq_en <= avs_writedata[2];
      end
      // A commit in the same cycle as IRQ_CLR wins, so the flag ends up set.
      if (w_commit)                           r_irq_flag <= 1'b1;
      else if (w_wr_ctrl && avs_writedata[3]) r_irq_flag <= 1'b0;
      if (w_commit) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (avs_address == ADDR_W'(i)) begin
        w_rd[31]                = r_sh_en[i];
        w_rd[2*COORD_W+FLAG_W-1:0] = {r_sh_f[i], r_sh_y[i], r_sh_x[i]};
      end
    end
    if (avs_address == A_CTRL) w_rd[2:0]  = {r_irq_en, r_auto, r_pend};
    if (avs_address == A_STAT) w_rd[16:0] = {r_irq_flag, r_cnt};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= w_rd;
  end

  assign irq       = r_irq_flag & r_irq_en;
  assign spr_en    = r_act_en;
  assign spr_x     = r_act_x;
  assign spr_y     = r_act_y;
  assign spr_flags = r_act_f;

endmodule
